// File: rtl/regression_predictor_pkg.sv
// Shared definitions for the regression predictor: FSM state encoding,
// default Q-format (Q10.10 in a 20-bit word), run length and accumulator width.
// Imported by regression_predictor and regression_predictor_line_eval.
package regression_predictor_pkg;

    localparam int Q_N         = 20;   // word width of x/y/beta/y_hat/residual/mse
    localparam int Q_F         = 10;   // fraction bits of every word
    localparam int SAMPLES_DEF = 150;  // samples per run, also the MSE divisor
    localparam int ACC_W_DEF   = 48;   // squared-error accumulator width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Largest positive value of an n-bit two's-complement word, used as the
    // MSE saturation ceiling.
    function automatic logic [Q_N-1:0] pos_max(input int n);
        logic [Q_N-1:0] v;
        v = '0;
        for (int i = 0; i < n - 1; i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/regression_predictor_line_eval.sv
// Purpose : combinational y_hat = beta0 + beta1*x, err = y - y_hat, sq = err^2.
// Latency : 0 cycles (pure combinational datapath).
// Backpressure: none; the caller decides when results are consumed.
// Ports: beta0/beta1/x/y are signed N-bit Q(N-F).F inputs; yhat/err are N-bit
//        wrapping results; sq is the full 2N-bit Q(2F) square of err.
module regression_predictor_line_eval
    import regression_predictor_pkg::*;
#(
    parameter int N = Q_N,
    parameter int F = Q_F
) (
    input  logic signed [N-1:0]   beta0,
    input  logic signed [N-1:0]   beta1,
    input  logic signed [N-1:0]   x,
    input  logic signed [N-1:0]   y,
    output logic signed [N-1:0]   yhat,
    output logic signed [N-1:0]   err,
    output logic signed [2*N-1:0] sq
);

    logic signed [2*N-1:0] prod;

    // Operands are sign-extended to the 2N-bit context before multiplying,
    // so the product is exact. Dropping the low F bits of a two's-complement
    // value rounds toward -inf, which is the intended truncation.
    assign prod = beta1 * x;
    assign yhat = beta0 + prod[N+F-1:F];
    assign err  = y - yhat;
    assign sq   = err * err;

endmodule

// File: rtl/regression_predictor.sv
// Purpose : evaluates a fitted line over SAMPLES (x,y) pairs, streams y_hat and
//           residual per sample, then reports the mean squared error.
// Latency : 1 cycle accept->out_valid; done 2 cycles after the final output pop.
// Backpressure: valid/ready both sides; in_ready drops while the output register
//           is full and not being popped, so nothing is lost or duplicated.
// Ports: clk/rst (async active-high); start + beta0_bus/beta1_bus latch the
//        coefficients; x_bus/y_bus/in_valid/in_ready input stream;
//        yhat_bus/err_bus/out_valid/out_ready output stream; mse_bus/busy/done status.
module regression_predictor
    import regression_predictor_pkg::*;
#(
    parameter int N       = Q_N,
    parameter int F       = Q_F,
    parameter int SAMPLES = SAMPLES_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] beta0_bus,
    input  logic [N-1:0] beta1_bus,
    input  logic [N-1:0] x_bus,
    input  logic [N-1:0] y_bus,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] yhat_bus,
    output logic [N-1:0] err_bus,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] mse_bus,
    output logic         busy,
    output logic         done
);

    localparam int CNT_W = $clog2(SAMPLES + 1);

    state_t             state_q, state_d;
    logic [N-1:0]       beta0_q, beta0_d;
    logic [N-1:0]       beta1_q, beta1_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]   pop_cnt_q, pop_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [N-1:0]       yhat_q, yhat_d;
    logic [N-1:0]       err_q, err_d;
    logic [N-1:0]       mse_q, mse_d;

    logic [N-1:0]       yhat_c;
    logic [N-1:0]       err_c;
    logic [2*N-1:0]     sq_c;
    logic [ACC_W-1:0]   sq_ext;
    logic [ACC_W-1:0]   q_c;
    logic [N-1:0]       mse_c;
    logic               in_ready_c;
    logic               accept;
    logic               pop;

    regression_predictor_line_eval #(
        .N (N),
        .F (F)
    ) u_line_eval (
        .beta0 (beta0_q),
        .beta1 (beta1_q),
        .x     (x_bus),
        .y     (y_bus),
        .yhat  (yhat_c),
        .err   (err_c),
        .sq    (sq_c)
    );

    assign sq_ext = {{(ACC_W - 2*N){sq_c[2*N-1]}}, sq_c};

    // Division by a constant; the accumulator is treated as unsigned.
    assign q_c = acc_q / ACC_W'(SAMPLES);

    always_comb begin
        mse_c = q_c[N+F-1:F];
        if (q_c >= (ACC_W'(1) << (N + F - 1))) begin
            mse_c = pos_max(N);
        end
    end

    // A pop frees the output register in the same cycle, so a new sample can
    // be accepted back-to-back while the downstream keeps out_ready high.
    assign in_ready_c = (state_q == ST_RUN) &&
                        (acc_cnt_q < CNT_W'(SAMPLES)) &&
                        (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready_c;
    assign pop        = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        beta0_d     = beta0_q;
        beta1_d     = beta1_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        out_valid_d = out_valid_q;
        yhat_d      = yhat_q;
        err_d       = err_q;
        mse_d       = mse_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    beta0_d     = beta0_bus;
                    beta1_d     = beta1_bus;
                    acc_d       = '0;
                    acc_cnt_d   = '0;
                    pop_cnt_d   = '0;
                    out_valid_d = 1'b0;
                    mse_d       = '0;
                end
            end
            ST_RUN: begin
                if (pop) begin
                    pop_cnt_d   = pop_cnt_q + CNT_W'(1);
                    out_valid_d = 1'b0;
                    if (pop_cnt_q == CNT_W'(SAMPLES - 1)) begin
                        state_d = ST_FINISH;
                    end
                end
                if (accept) begin
                    acc_cnt_d   = acc_cnt_q + CNT_W'(1);
                    acc_d       = acc_q + sq_ext;
                    out_valid_d = 1'b1;
                    yhat_d      = yhat_c;
                    err_d       = err_c;
                end
            end
            ST_FINISH: begin
                mse_d   = mse_c;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beta0_q     <= '0;
            beta1_q     <= '0;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            pop_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            yhat_q      <= '0;
            err_q       <= '0;
            mse_q       <= '0;
        end else begin
            state_q     <= state_d;
            beta0_q     <= beta0_d;
            beta1_q     <= beta1_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            out_valid_q <= out_valid_d;
            yhat_q      <= yhat_d;
            err_q       <= err_d;
            mse_q       <= mse_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign yhat_bus  = yhat_q;
    assign err_bus   = err_q;
    assign mse_bus   = mse_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_FINISH);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_regression_predictor.sv
module tb_regression_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] beta0_bus, beta1_bus, x_bus, y_bus;
    logic        in_valid, in_ready;
    logic [19:0] yhat_bus, err_bus, mse_bus;
    logic        out_valid, out_ready, busy, done;

    int errors = 0;
    int checks = 0;

    logic [19:0] xs [0:149];
    logic [19:0] ys [0:149];
    logic [19:0] ey [0:149];
    logic [19:0] ee [0:149];

    regression_predictor dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .beta0_bus (beta0_bus),
        .beta1_bus (beta1_bus),
        .x_bus     (x_bus),
        .y_bus     (y_bus),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .yhat_bus  (yhat_bus),
        .err_bus   (err_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mse_bus   (mse_bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Entered and left at posedge+1.
    task automatic do_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [19:0] b0, input logic [19:0] b1);
        start     = 1'b1;
        beta0_bus = b0;
        beta1_bus = b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        // Scramble the coefficient buses: the latched values must be used.
        beta0_bus = 20'h5A5A5;
        beta1_bus = 20'h3C3C3;
    endtask

    // Line y = 1.0 + 2.0*x with residual 0.5 for sample k, x = k.
    task automatic fill_line(input int n);
        for (int k = 0; k < n; k++) begin
            xs[k] = 20'(k * 1024);
            ey[k] = 20'(1024 + 2048 * k);
            ys[k] = 20'(1536 + 2048 * k);
            ee[k] = 20'd512;
        end
    endtask

    // Streams n samples from xs/ys, checks each popped output against ey/ee.
    // When stall_at >= 0, out_ready is held low for 5 cycles once stall_at
    // outputs have been popped.
    task automatic run_stream(input int n, input int stall_at);
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        int          stall = 0;
        bit          stalled = 1'b0;
        bit          acc_now, pop_now;
        logic [19:0] hy = '0;
        logic [19:0] he = '0;
        logic [47:0] ha = '0;
        while (got < n && cyc < n * 3 + 50) begin
            if (!stalled && got == stall_at && out_valid) begin
                stall   = 5;
                stalled = 1'b1;
                hy = yhat_bus;
                he = err_bus;
                ha = dut.acc_q;
            end
            in_valid = (sent < n);
            if (sent < n) begin
                x_bus = xs[sent];
                y_bus = ys[sent];
            end
            out_ready = (stall == 0);
            #1;
            if (stall > 0) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || yhat_bus !== hy ||
                    err_bus !== he || dut.acc_q !== ha) begin
                    errors++;
                    $display("FAIL stall_hold: got rdy=%b vld=%b yhat=%h err=%h acc=%h required rdy=0 vld=1 yhat=%h err=%h acc=%h",
                             in_ready, out_valid, yhat_bus, err_bus, dut.acc_q, hy, he, ha);
                end
                stall--;
            end
            acc_now = in_valid && in_ready;
            pop_now = out_valid && out_ready;
            if (pop_now) begin
                checks++;
                if (yhat_bus !== ey[got] || err_bus !== ee[got]) begin
                    errors++;
                    $display("FAIL sample_%0d: got yhat=%h err=%h required yhat=%h err=%h",
                             got, yhat_bus, err_bus, ey[got], ee[got]);
                end
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (acc_now) sent++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != n || sent != n) begin
            errors++;
            $display("FAIL stream_count: got popped=%0d accepted=%0d required %0d each", got, sent, n);
        end
    endtask

    task automatic test_reset();
        start = 0; in_valid = 1; out_ready = 1;
        beta0_bus = 0; beta1_bus = 0; x_bus = 20'h12345; y_bus = 20'h54321;
        do_reset();
        checks++;
        if (out_valid !== 0 || in_ready !== 0 || busy !== 0 || done !== 0 ||
            yhat_bus !== 0 || err_bus !== 0 || mse_bus !== 0) begin
            errors++;
            $display("FAIL reset_state: got vld=%b rdy=%b busy=%b done=%b yhat=%h err=%h mse=%h required all 0",
                     out_valid, in_ready, busy, done, yhat_bus, err_bus, mse_bus);
        end
        in_valid = 0;
    endtask

    task automatic test_basic();
        do_start(20'd1024, 20'd2048);
        checks++;
        if (busy !== 1 || in_ready !== 1 || done !== 0) begin
            errors++;
            $display("FAIL basic_run_state: got busy=%b rdy=%b done=%b required 1 1 0", busy, in_ready, done);
        end
        x_bus = 20'd3072; y_bus = 20'd7680; in_valid = 1; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0;
        checks++;
        if (out_valid !== 1 || yhat_bus !== 20'd7168 || err_bus !== 20'd512) begin
            errors++;
            $display("FAIL basic_predict: got vld=%b yhat=%0d err=%0d required 1 7168 512", out_valid, yhat_bus, err_bus);
        end
        checks++;
        if (dut.acc_q !== 48'd262144) begin
            errors++;
            $display("FAIL basic_acc: got %0d required 262144", dut.acc_q);
        end
        checks++;
        if (in_ready !== 0) begin
            errors++;
            $display("FAIL basic_full_blocks: got in_ready=%b required 0", in_ready);
        end
        out_ready = 1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 0) begin
            errors++;
            $display("FAIL basic_pop: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_negative_trunc();
        do_reset();
        do_start(20'd0, 20'hFFC00);
        x_bus = 20'd1; y_bus = 20'd0; in_valid = 1; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        checks++;
        if (out_valid !== 1 || yhat_bus !== 20'hFFFFF || err_bus !== 20'd1) begin
            errors++;
            $display("FAIL neg_trunc: got vld=%b yhat=%h err=%h required 1 fffff 00001", out_valid, yhat_bus, err_bus);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fill_line(20);
        do_start(20'd1024, 20'd2048);
        run_stream(20, 5);
        checks++;
        if (dut.acc_q !== 48'd5242880) begin
            errors++;
            $display("FAIL bp_acc: got %0d required 5242880", dut.acc_q);
        end
    endtask

    task automatic test_full_run();
        do_reset();
        fill_line(150);
        do_start(20'd1024, 20'd2048);
        run_stream(150, -1);
        checks++;
        if (done !== 0 || busy !== 1) begin
            errors++;
            $display("FAIL full_finish: got done=%b busy=%b required 0 1", done, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1 || busy !== 0 || mse_bus !== 20'd256 || in_ready !== 0) begin
            errors++;
            $display("FAIL full_done: got done=%b busy=%b mse=%0d rdy=%b required 1 0 256 0", done, busy, mse_bus, in_ready);
        end
        checks++;
        if (dut.acc_q !== 48'd39321600) begin
            errors++;
            $display("FAIL full_acc: got %0d required 39321600", dut.acc_q);
        end
    endtask

    // Starts from DONE of the previous run, without a reset.
    task automatic test_saturation();
        for (int k = 0; k < 150; k++) begin
            xs[k] = 20'(k); ys[k] = 20'h7FFFF; ey[k] = 20'd0; ee[k] = 20'h7FFFF;
        end
        do_start(20'd0, 20'd0);
        checks++;
        if (done !== 0 || mse_bus !== 0 || busy !== 1) begin
            errors++;
            $display("FAIL restart_clear: got done=%b mse=%h busy=%b required 0 0 1", done, mse_bus, busy);
        end
        run_stream(150, -1);
        @(posedge clk); #1;
        checks++;
        if (done !== 1 || mse_bus !== 20'h7FFFF) begin
            errors++;
            $display("FAIL saturate: got done=%b mse=%h required 1 7ffff", done, mse_bus);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        fill_line(41);
        do_start(20'd1024, 20'd2048);
        run_stream(40, -1);
        x_bus = xs[40]; y_bus = ys[40]; in_valid = 1; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 0 || in_ready !== 0 || busy !== 0 || done !== 0 ||
            yhat_bus !== 0 || err_bus !== 0 || mse_bus !== 0) begin
            errors++;
            $display("FAIL async_reset: got vld=%b rdy=%b busy=%b done=%b yhat=%h err=%h mse=%h required all 0",
                     out_valid, in_ready, busy, done, yhat_bus, err_bus, mse_bus);
        end
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        do_start(20'd0, 20'd1024);
        x_bus = 20'd2048; y_bus = 20'd2148; in_valid = 1; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        checks++;
        if (out_valid !== 1 || yhat_bus !== 20'd2048 || err_bus !== 20'd100) begin
            errors++;
            $display("FAIL post_reset_coeffs: got vld=%b yhat=%0d err=%0d required 1 2048 100", out_valid, yhat_bus, err_bus);
        end
        checks++;
        if (dut.acc_cnt_q !== 1 || dut.acc_q !== 48'd10000) begin
            errors++;
            $display("FAIL post_reset_count: got cnt=%0d acc=%0d required 1 10000", dut.acc_cnt_q, dut.acc_q);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative_trunc();
        test_backpressure();
        test_full_run();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
